dmem_mmio: RTL and testbench

//  Data-side memory controller behind the processor's data memory port (mem_*).

---
 rtl/dmem_mmio.sv | 139 +++++++++++++
 tb/tb_dmem_mmio.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-side memory controller: synchronous word RAM plus an MMIO window holding a UART TX byte FIFO.
// Loads return a right-aligned word one cycle after accept; stores are lane-shifted here.
module dmem_mmio #(
    parameter int    AW       = 10,
    parameter string INIT_HEX = "",
    parameter int    TXDEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_oe,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_we,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        err
);
    localparam int          PW          = $clog2(TXDEPTH);
    localparam logic [31:0] TXDATA_ADDR = 32'hF000_0000;
    localparam logic [31:0] TXSTAT_ADDR = 32'hF000_0004;
    localparam logic [PW:0] PTR_ONE     = {{PW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_STAT} src_t;

    logic [31:0] r_mem [0:(1<<AW)-1];
    logic [31:0] r_ram_q;
    logic [4:0]  r_stat_q;
    logic [1:0]  r_shift;
    src_t        r_src;
    logic        r_valid;
    logic        r_err;
    logic [7:0]  r_fifo [0:TXDEPTH-1];
    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;

    logic          w_is_ram;
    logic          w_is_txd;
    logic          w_is_txs;
    logic          w_unmapped;
    logic          w_full;
    logic          w_empty;
    logic [PW:0]   w_count;
    logic [31:0]   w_count_ext;
    logic [3:0]    w_cnt_sat;
    logic          w_acc;
    logic          w_load;
    logic          w_store;
    logic [7:0]    w_be;
    logic [31:0]   w_wdata;
    logic          w_misalign;
    logic          w_ram_we;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_widx;
    logic [31:0]   w_sel_word;

    assign w_is_ram   = (mem_addr[31:28] == 4'h0);
    assign w_is_txd   = (mem_addr == TXDATA_ADDR);
    assign w_is_txs   = (mem_addr == TXSTAT_ADDR);
    assign w_unmapped = !(w_is_ram || w_is_txd || w_is_txs);
    assign w_widx     = mem_addr[2 +: AW];

    assign w_count     = r_wptr - r_rptr;
    assign w_count_ext = {{(31 - PW){1'b0}}, w_count};
    assign w_cnt_sat   = (w_count_ext > 32'd15) ? 4'hF : w_count_ext[3:0];
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

    // Ready depends only on address and registered FIFO state so EM never sees a stall loop.
    assign mem_ready = !(w_is_txd && w_full);
    assign w_acc     = mem_oe && mem_ready;
    assign w_load    = w_acc && (mem_we == 4'b0000);
    assign w_store   = w_acc && (mem_we != 4'b0000);

    assign w_be       = {4'b0000, mem_we} << mem_addr[1:0];
    assign w_wdata    = mem_wdata << {mem_addr[1:0], 3'b000};
    assign w_misalign = (w_be[7:4] != 4'b0000);
    assign w_ram_we   = w_store && w_is_ram && !w_misalign;

    assign w_push = w_store && w_is_txd;
    assign w_pop  = !w_empty && tx_ready;

    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rptr[PW-1:0]];
    assign mem_valid = r_valid;
    assign err       = r_err;

    always_comb begin
        w_sel_word = 32'h0;
        case (r_src)
            SRC_RAM:  w_sel_word = r_ram_q;
            SRC_STAT: w_sel_word = {27'b0, r_stat_q};
            default:  w_sel_word = 32'h0;
        endcase
        mem_rdata = w_sel_word >> {r_shift, 3'b000};
    end

    // RAM and FIFO storage carry no reset; only their control state does.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
        if (w_load && w_is_ram) r_ram_q <= r_mem[w_widx];
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr[PW-1:0]] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_src    <= SRC_ZERO;
            r_shift  <= 2'b00;
            r_stat_q <= 5'b0;
            r_err    <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= '0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_shift  <= mem_addr[1:0];
                r_stat_q <= {w_cnt_sat, w_full};
                if (w_is_ram)      r_src <= SRC_RAM;
                else if (w_is_txs) r_src <= SRC_STAT;
                else               r_src <= SRC_ZERO;
            end
            if ((w_acc && w_unmapped) || (w_store && w_is_ram && w_misalign)) r_err <= 1'b1;
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized bench for dmem_mmio: byte-level RAM model and TX queue model compared every cycle,
// plus directed sequences with hand-computed expectations.
module tb_dmem_mmio;
    localparam int          AW       = 10;
    localparam int          TXD      = 8;
    localparam int          RAMBYTES = 4 << AW;
    localparam logic [31:0] TXDATA_A = 32'hF000_0000;
    localparam logic [31:0] TXSTAT_A = 32'hF000_0004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_oe;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        err;

    dmem_mmio #(.AW(AW), .TXDEPTH(TXD)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .err(err)
    );

    always #5 clk = ~clk;

    logic [7:0]  m_mem [int];
    logic [7:0]  m_q [$];
    logic [7:0]  seen [$];
    logic        m_valid;
    logic        m_err;
    logic [31:0] m_rdata;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_ready(input logic [31:0] a);
        return !(a == TXDATA_A && m_q.size() == TXD);
    endfunction

    function automatic int bidx(input logic [31:0] a);
        return int'(a[27:0]) % RAMBYTES;
    endfunction

    function automatic void m_reset();
        m_valid = 1'b0;
        m_rdata = 32'h0;
        m_err   = 1'b0;
        m_q.delete();
    endfunction

    // What one clock edge does to the architectural state, given this cycle's request.
    function automatic void m_apply(input logic oe, input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] we, input logic trdy);
        logic        pop, acc, push, bad;
        logic [7:0]  pushb;
        logic [31:0] w;
        int          base, off, cnt;
        pop   = (m_q.size() != 0) && trdy;
        acc   = oe && m_ready(a);
        push  = 1'b0;
        pushb = 8'h00;
        base  = bidx(a) - (bidx(a) % 4);
        off   = bidx(a) % 4;
        m_valid = 1'b0;
        if (acc && we == 4'b0000) begin
            m_valid = 1'b1;
            if (a[31:28] == 4'h0) begin
                w = 32'h0;
                for (int k = 0; k < 4; k++) w[8*k +: 8] = m_mem[base + k];
                m_rdata = w >> (8 * off);
            end else if (a == TXSTAT_A) begin
                cnt = m_q.size();
                m_rdata = 32'(((cnt > 15 ? 15 : cnt) * 2) + (cnt == TXD ? 1 : 0));
            end else begin
                m_rdata = 32'h0;
                if (a != TXDATA_A) m_err = 1'b1;
            end
        end else if (acc) begin
            if (a[31:28] == 4'h0) begin
                bad = 1'b0;
                for (int k = 0; k < 4; k++) if (we[k] && off + k > 3) bad = 1'b1;
                if (bad) m_err = 1'b1;
                else for (int k = 0; k < 4; k++) if (we[k]) m_mem[base + off + k] = wd[8*k +: 8];
            end else if (a == TXDATA_A) begin
                push  = 1'b1;
                pushb = wd[7:0];
            end else if (a != TXSTAT_A) begin
                m_err = 1'b1;
            end
        end
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(pushb);
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("mem_valid", 32'(mem_valid), 32'(m_valid));
            chk("mem_rdata", mem_rdata, m_rdata);
            chk("err", 32'(err), 32'(m_err));
            chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
            chk("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
            chk("mem_ready", 32'(mem_ready), 32'(m_ready(mem_addr)));
        end
    end

    task automatic present(input logic oe, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] we, input logic trdy);
        mem_oe = oe; mem_addr = a; mem_wdata = wd; mem_we = we; tx_ready = trdy;
    endtask

    task automatic step(input logic oe, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] we, input logic trdy);
        present(oe, a, wd, we, trdy);
        if (tx_valid && trdy) seen.push_back(tx_data);
        @(posedge clk);
        #1;
        m_apply(oe, a, wd, we, trdy);
    endtask

    initial begin
        int          pushes, cyc, r;
        logic        trdy;
        logic [31:0] wa;

        rst_n = 1'b1;
        present(1'b0, 32'h0, 32'h0, 4'b0000, 1'b0);
        m_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;
        chk("reset_valid", 32'(mem_valid), 32'h0);
        chk("reset_rdata", mem_rdata, 32'h0);
        chk("reset_txvalid", 32'(tx_valid), 32'h0);
        chk("reset_err", 32'(err), 32'h0);

        // SW then LW
        step(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
        step(1'b1, 32'h10, 32'h0, 4'b0000, 1'b0);
        chk("lw_valid", 32'(mem_valid), 32'h1);
        chk("lw_data", mem_rdata, 32'hDEADBEEF);
        chk("lw_err", 32'(err), 32'h0);
        step(1'b0, 32'h0, 32'h0, 4'b0000, 1'b0);
        chk("valid_pulse", 32'(mem_valid), 32'h0);
        chk("rdata_hold", mem_rdata, 32'hDEADBEEF);

        // SB into top lane
        step(1'b1, 32'h13, 32'h000000AA, 4'b0001, 1'b0);
        step(1'b1, 32'h10, 32'h0, 4'b0000, 1'b0);
        chk("sb_word", mem_rdata, 32'hAAADBEEF);
        step(1'b1, 32'h13, 32'h0, 4'b0000, 1'b0);
        chk("lb_shift", mem_rdata, 32'h000000AA);

        // Misaligned SH is dropped and flags err
        step(1'b1, 32'h13, 32'h00001234, 4'b0011, 1'b0);
        chk("misalign_err", 32'(err), 32'h1);
        step(1'b1, 32'h10, 32'h0, 4'b0000, 1'b0);
        chk("misalign_nowrite", mem_rdata, 32'hAAADBEEF);
        chk("err_sticky", 32'(err), 32'h1);

        for (int w2 = 0; w2 < 16; w2++) step(1'b1, 32'h40 + 32'(4 * w2), $urandom, 4'b1111, 1'b0);

        // Fill FIFO, observe refusal, then drain
        seen.delete();
        for (int i = 1; i <= 8; i++) step(1'b1, TXDATA_A, 32'(i), 4'b0001, 1'b0);
        step(1'b1, TXSTAT_A, 32'h0, 4'b0000, 1'b0);
        chk("txstat_full", mem_rdata, 32'h11);
        present(1'b1, TXDATA_A, 32'h9, 4'b0001, 1'b0);
        #1 chk("ready_full", 32'(mem_ready), 32'h0);
        step(1'b1, TXDATA_A, 32'h9, 4'b0001, 1'b0);
        chk("head_held", 32'(tx_data), 32'h01);
        present(1'b1, TXDATA_A, 32'h9, 4'b0001, 1'b1);
        #1 chk("ready_full_pop", 32'(mem_ready), 32'h0);
        step(1'b1, TXDATA_A, 32'h9, 4'b0001, 1'b1);
        present(1'b1, TXDATA_A, 32'h9, 4'b0001, 1'b1);
        #1 chk("ready_after_pop", 32'(mem_ready), 32'h1);
        step(1'b1, TXDATA_A, 32'h9, 4'b0001, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 32'h0, 4'b0000, 1'b1);
        chk("drain_count", 32'(seen.size()), 32'd9);
        for (int k = 0; k < 9; k++) chk("drain_order", (k < seen.size()) ? 32'(seen[k]) : 32'hFFFF_FFFF, 32'(k + 1));

        // Random load/store/push mix over the RAM window and FIFO wrap
        pushes = 0;
        cyc = 0;
        while ((pushes < 3 * TXD + 4 || cyc < 200) && cyc < 4000) begin
            r    = int'($urandom_range(0, 9));
            trdy = ($urandom_range(0, 2) != 0);
            wa   = 32'h40 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) wa = wa + 32'(1 << (AW + 2));
            case (r)
                0, 1:    step(1'b1, wa, 32'h0, 4'b0000, trdy);
                2:       step(1'b1, wa & ~32'h3, $urandom, 4'b1111, trdy);
                3:       step(1'b1, wa, $urandom, 4'b0011, trdy);
                4:       step(1'b1, wa, $urandom, 4'b0001, trdy);
                5, 6, 7: begin
                    if (m_ready(TXDATA_A)) pushes++;
                    step(1'b1, TXDATA_A, $urandom, 4'b0001, trdy);
                end
                8:       step(1'b1, TXSTAT_A, 32'h0, 4'b0000, trdy);
                default: step(1'b0, wa, 32'h0, 4'b0000, trdy);
            endcase
            cyc++;
        end
        n_chk++;
        if (pushes < 3 * TXD) begin
            n_fail++;
            $display("FAIL push_budget: got %0d pushes, need %0d", pushes, 3 * TXD);
        end
        for (int i = 0; i < TXD + 2; i++) step(1'b0, 32'h0, 32'h0, 4'b0000, 1'b1);

        // Reset in the cycle after a load accept
        for (int i = 0; i < 3; i++) step(1'b1, TXDATA_A, 32'(8'hA0 + i), 4'b0001, 1'b0);
        step(1'b1, 32'h10, 32'h0, 4'b0000, 1'b0);
        chk("pre_reset_valid", 32'(mem_valid), 32'h1);
        chk("pre_reset_data", mem_rdata, 32'hAAADBEEF);
        present(1'b0, 32'h0, 32'h0, 4'b0000, 1'b0);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_valid", 32'(mem_valid), 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_txvalid", 32'(tx_valid), 32'h0);
        chk("rst_txdata", 32'(tx_data), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 32'h10, 32'h0, 4'b0000, 1'b0);
        chk("ram_kept", mem_rdata, 32'hAAADBEEF);
        step(1'b1, TXSTAT_A, 32'h5, 4'b1111, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'b0000, 1'b0);
        chk("txstat_store_noerr", 32'(err), 32'h0);
        chk("txstat_store_nopush", 32'(tx_valid), 32'h0);
        step(1'b1, 32'hF000_0008, 32'h0, 4'b0000, 1'b0);
        chk("unmapped_err", 32'(err), 32'h1);
        chk("unmapped_rdata", mem_rdata, 32'h0);
        step(1'b1, 32'h2000_0010, 32'h0, 4'b0000, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'b0000, 1'b0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
